// File: rtl/row_debounce.sv
// Keypad row conditioner: synchronises active-low row pins, then debounces each row with its own counter.
// Emits press/release pulses and a registered single-key summary. Define GLITCH_COUNT_EN to count aborted transitions.
module row_debounce #(
    parameter int unsigned WIDTH         = 4,
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned STABLE_CYCLES = 512
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         rows_raw,
    input  logic                     restart,
    output logic [WIDTH-1:0]         rows_stable,
    output logic [WIDTH-1:0]         press_pulse,
    output logic [WIDTH-1:0]         release_pulse,
    output logic                     any_pressed,
    output logic                     key_valid,
    output logic                     multi_key,
    output logic [$clog2(WIDTH)-1:0] row_index,
    output logic [7:0]               glitch_count
);

    localparam int unsigned CntW = $clog2(STABLE_CYCLES);
    localparam int unsigned IdxW = $clog2(WIDTH);
    localparam logic [CntW-1:0] CntMax = CntW'(STABLE_CYCLES - 1);

    // Synchroniser chain
    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] rows_sync;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '1;
            end
        end else begin
            sync_q[0] <= rows_raw;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign rows_sync = sync_q[SYNC_STAGES-1];

    // Debounce state
    logic [CntW-1:0]  cnt_q [WIDTH];
    logic [CntW-1:0]  cnt_d [WIDTH];
    logic [WIDTH-1:0] stable_q, stable_d;
    logic [WIDTH-1:0] press_q, press_d;
    logic [WIDTH-1:0] release_q, release_d;
    logic             any_q, any_d;
    logic             key_valid_q, key_valid_d;
    logic             multi_q, multi_d;
    logic [IdxW-1:0]  row_index_q, row_index_d;
    logic [WIDTH-1:0] low_d;

    always_comb begin
        stable_d  = stable_q;
        press_d   = '0;
        release_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (restart) begin
                cnt_d[i] = '0;
            end else if (rows_sync[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CntMax) begin
                cnt_d[i]     = '0;
                stable_d[i]  = rows_sync[i];
                press_d[i]   = ~rows_sync[i];
                release_d[i] = rows_sync[i];
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    // Summary is taken from the next stable value so it lines up with rows_stable.
    always_comb begin
        low_d       = ~stable_d;
        any_d       = |low_d;
        multi_d     = |(low_d & (low_d - 1'b1));
        key_valid_d = any_d & ~multi_d;
        row_index_d = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (low_d[i]) begin
                row_index_d = IdxW'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
            stable_q    <= '1;
            press_q     <= '0;
            release_q   <= '0;
            any_q       <= 1'b0;
            key_valid_q <= 1'b0;
            multi_q     <= 1'b0;
            row_index_q <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            stable_q    <= stable_d;
            press_q     <= press_d;
            release_q   <= release_d;
            any_q       <= any_d;
            key_valid_q <= key_valid_d;
            multi_q     <= multi_d;
            row_index_q <= row_index_d;
        end
    end

    assign rows_stable   = stable_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign any_pressed   = any_q;
    assign key_valid     = key_valid_q;
    assign multi_key     = multi_q;
    assign row_index     = row_index_q;

`ifdef GLITCH_COUNT_EN
    logic [WIDTH-1:0] abort;
    logic [7:0]       glitch_q, glitch_d;

    // An abort is a partly-counted row falling back to its stable level; restart clears are excluded.
    always_comb begin
        abort = '0;
        for (int i = 0; i < WIDTH; i++) begin
            abort[i] = !restart && (cnt_q[i] != '0) && (rows_sync[i] == stable_q[i]);
        end
        glitch_d = glitch_q;
        if ((|abort) && (glitch_q != 8'hFF)) begin
            glitch_d = glitch_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            glitch_q <= 8'd0;
        end else begin
            glitch_q <= glitch_d;
        end
    end

    assign glitch_count = glitch_q;
`else
    assign glitch_count = 8'd0;
`endif

endmodule

// File: doc/row_debounce.md
Name: row_debounce

Overview:
Upstream conditioning stage for the keypad scanner. Takes the raw active-low keypad row lines straight from the pins and synchronises them into the clk domain. Each row is debounced independently with a consecutive-sample counter. Outputs are clean stable row levels, one-cycle press/release pulses and a decoded single-key summary. The scanner consumes these in place of its bare register synchroniser.

Parameters:
WIDTH, 4, number of row lines.
SYNC_STAGES, 2, synchroniser flop depth per row; legal range 2 or more.
STABLE_CYCLES, 512, consecutive differing samples needed to accept a new level; legal range 2 or more; counter width is $clog2(STABLE_CYCLES).

Ports:
clk  input  1  system clock (LSOSC-derived in top).
reset  input  1  asynchronous, active-low reset.
rows_raw  input  WIDTH  raw row pins; active-low, idle 1.
restart  input  1  synchronous pulse from the scanner on every column change; re-qualifies all rows.
rows_stable  output  WIDTH  debounced row levels.
press_pulse  output  WIDTH  one-cycle pulse per row on a stable 1->0 transition.
release_pulse  output  WIDTH  one-cycle pulse per row on a stable 0->1 transition.
any_pressed  output  1  high when any rows_stable bit is 0.
key_valid  output  1  high when exactly one rows_stable bit is 0.
multi_key  output  1  high when two or more rows_stable bits are 0.
row_index  output  $clog2(WIDTH)  index of the lowest-numbered low stable bit; 0 when none is low.
glitch_count  output  8  aborted-transition counter (see Optional Feature).

Behaviour:
- Reset (asynchronous, active-low):
  - All synchroniser flops = 1.
  - rows_stable = all 1s.
  - All counters = 0.
  - press_pulse and release_pulse = 0.
  - any_pressed, key_valid, multi_key, row_index, glitch_count = 0.
  - Reset asserted mid-debounce abandons the transition; no pulse is emitted.
- Synchroniser: rows_raw passes through SYNC_STAGES flops, giving rows_sync. No logic sits between the stages.
- Per-row counter cnt[i], evaluated every clock:
  - rows_sync[i] == rows_stable[i] -> cnt[i] <= 0.
  - rows_sync[i] != rows_stable[i] and cnt[i] < STABLE_CYCLES-1 -> cnt[i] <= cnt[i]+1.
  - rows_sync[i] != rows_stable[i] and cnt[i] == STABLE_CYCLES-1 -> rows_stable[i] <= rows_sync[i]; cnt[i] <= 0; the matching pulse bit is asserted in the same cycle rows_stable[i] first shows the new value.
- Latency: a clean raw edge reaches rows_stable exactly SYNC_STAGES+STABLE_CYCLES rising edges after it is first sampled.
- Pulses are registered and last exactly one clock. press and release for the same row can never coincide. Rows are independent, so several pulse bits may be high together.
- restart:
  - Forces every cnt[i] to 0 and suppresses any flip and pulse in that cycle; restart wins over a simultaneous threshold hit.
  - rows_stable and the synchroniser are unaffected.
- Summary outputs (any_pressed, key_valid, multi_key, row_index) are registered from the next value of rows_stable, so they update in the same cycle as rows_stable.
- No wrap-around: a counter at threshold either flips or clears; it never increments past STABLE_CYCLES-1.

Optional Feature:
Macro GLITCH_COUNT_EN.
- Defined: glitch_count increments whenever any cnt[i] is nonzero and is cleared because rows_sync[i] returned to rows_stable[i].
  - Simultaneous aborts on several rows count as 1 per cycle.
  - Clears caused by restart do not count.
  - Saturates at 255; cleared only by reset.
- Undefined: no counter logic is generated and glitch_count is tied to 0.

Test Plan:
All tests use WIDTH=4, SYNC_STAGES=2, STABLE_CYCLES=8.
1. Reset with rows_raw=1111, then release reset -> rows_stable=1111; all pulses 0; any_pressed=0; key_valid=0; row_index=0.
2. rows_raw 1111->1101 and held -> rows_stable=1101 exactly 10 clocks later; press_pulse=0010 for 1 clock; key_valid=1; row_index=1; any_pressed=1.
3. Bounce: row0 low for 5 clocks, then high -> rows_stable stays 1111; no pulses; glitch_count=1 with GLITCH_COUNT_EN, 0 without.
4. From stable 1101, raise rows_raw to 1111 -> release_pulse=0010 for 1 clock after 10 clocks; any_pressed=0.
5. rows_raw=1110 with restart pulsed on the 7th counting clock -> no flip at clock 10; flip occurs 8 clocks after the restart; glitch_count unchanged.
6. rows_raw=1010 -> multi_key=1; key_valid=0; row_index=0; press_pulse=0101 in a single cycle.
